mux_4b: RTL and testbench
=========================

// Module: mux_4b
// PURPOSE
//   Data-source selector for the 4-bit computer datapath.
//   - Picks one nibble from either the program ROM output or the RAM read data.
//   - Presents that nibble on the internal bus, registered, with a valid flag.
//   - Sits between the ROM/RAM read ports and the ALU/register-file input bus.
// PARAMETERS
//   WIDTH  4  data width of programROM, Ram and outBits (legal: >= 1)
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      reset, asynchronous, active-low
//   enable      in   1      1 = capture the selected source this cycle
//   sel         in   1      source select: 0 = programROM, 1 = Ram
//   programROM  in   WIDTH  nibble from program ROM
//   Ram         in   WIDTH  nibble from RAM read port
//   outBits     out  WIDTH  registered selected data
//   out_valid   out  1      1 = outBits was loaded on the last clock edge
//   src_ram     out  1      registered sel that produced the current outBits
//   out_parity  out  1      XOR of outBits; port present only with MUX_PARITY_EN
// BEHAVIOUR
//   - Reset is asynchronous and active-low. While rst_n = 0:
//     - outBits = 0, out_valid = 0, src_ram = 0.
//     - out_parity = 0 when MUX_PARITY_EN is defined.
//     - Assertion mid-operation clears all outputs immediately, without waiting for clk.
//     - Deassertion is sampled synchronously; the first load happens at the first
//       rising edge with rst_n = 1 and enable = 1.
//   - Rising edge with enable = 1:
//     - outBits <= sel ? Ram : programROM.
//     - src_ram <= sel; out_valid <= 1.
//   - Rising edge with enable = 0:
//     - outBits and src_ram hold their values; out_valid <= 0.
//   - Latency: exactly 1 clk from input sampling to outBits.
//   - No combinational path from any input to any output.
//   - Selection is bit-exact: no arithmetic, no extension, no truncation. Width is WIDTH end to end.
//   - Back-to-back enables load every cycle. sel may change every cycle and each
//     edge uses the sel present at that edge.
//   - Equal source values (e.g. both 4'hF) give the same outBits for either sel.
//     src_ram still records sel.
//   - sel = X or Z while enable = 1 is a protocol violation.
//     - Simulation asserts it (disabled during reset).
//     - Synthesised behaviour is treated as sel = 0.
// CONFIGURATION
//   MUX_PARITY_EN defined:
//     - Adds out_parity = ^outBits, registered in the same cycle as outBits.
//     - Reset value 0.
//     - Holds while enable = 0.
//   MUX_PARITY_EN undefined:
//     - out_parity port and its logic are absent.
//     - All other behaviour is identical.
// STRUCTURE
//   - Package mux_pkg:
//     - MUX_WIDTH_DEF = 4.
//     - SEL_ROM = 1'b0, SEL_RAM = 1'b1.
//     - typedef logic [MUX_WIDTH_DEF-1:0] nibble_t.
//   - Top level: combinational select logic plus the sel X-check assertion.
//   - Sub-module mux_out_reg:
//     - Holds the enable-gated, async-reset register bank for outBits, src_ram
//       and out_valid, plus parity when MUX_PARITY_EN is defined.
//     - Same enable/reset semantics as the top level.
// TESTING
//   1. Reset, then enable=1, sel=0, programROM=4'hF, Ram=4'hF, one edge
//      -> outBits=4'hF, src_ram=0, out_valid=1.
//   2. enable=1, sel=1, Ram=4'h7, programROM=4'hF, one edge
//      -> outBits=4'h7, src_ram=1, out_valid=1.
//   3. Load 4'h7, then enable=0, sel=0, programROM=4'h3, two edges
//      -> outBits stays 4'h7, out_valid=0.
//   4. With outBits=4'hA, pull rst_n low between edges
//      -> outBits=0, out_valid=0, src_ram=0 before the next clk edge.
//   5. sel toggling 0,1,0,1 each edge, programROM=4'h2, Ram=4'hC
//      -> outBits 2,C,2,C one cycle after each sel value.
//   6. MUX_PARITY_EN defined, load 4'h7 then 4'h6
//      -> out_parity 1 then 0; compile without the macro -> port absent.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the mux_4b data-source selector.
// Optional feature macro used across this slice: MUX_PARITY_EN.
package mux_pkg;

  localparam int MUX_WIDTH_DEF = 4;

  localparam logic SEL_ROM = 1'b0;
  localparam logic SEL_RAM = 1'b1;

  typedef logic [MUX_WIDTH_DEF-1:0] nibble_t;

endpackage : mux_pkg

// File: rtl/mux_4b_if.sv
// Bus bundle for mux_4b: source nibbles and controls in, registered nibble out.
// MUX_PARITY_EN adds the out_parity signal to the bundle and both modports.
interface mux_4b_if
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF
);

  logic             enable;
  logic             sel;
  logic [WIDTH-1:0] programROM;
  logic [WIDTH-1:0] Ram;
  logic [WIDTH-1:0] outBits;
  logic             out_valid;
  logic             src_ram;
`ifdef MUX_PARITY_EN
  logic             out_parity;
`endif

`ifdef MUX_PARITY_EN
  // Side that produces the source data and consumes the selected nibble
  modport master (
    output enable, sel, programROM, Ram,
    input  outBits, out_valid, src_ram, out_parity
  );

  // The selector itself
  modport slave (
    input  enable, sel, programROM, Ram,
    output outBits, out_valid, src_ram, out_parity
  );
`else
  // Side that produces the source data and consumes the selected nibble
  modport master (
    output enable, sel, programROM, Ram,
    input  outBits, out_valid, src_ram
  );

  // The selector itself
  modport slave (
    input  enable, sel, programROM, Ram,
    output outBits, out_valid, src_ram
  );
`endif

endinterface : mux_4b_if

// File: rtl/mux_out_reg.sv
// Enable-gated output register bank for mux_4b: data, source flag, valid flag.
// MUX_PARITY_EN adds a registered parity bit of the loaded data.
module mux_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_src_ram,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
`ifdef MUX_PARITY_EN
  output logic             o_parity,
`endif
  output logic             o_src_ram
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_src_ram;
`ifdef MUX_PARITY_EN
  logic             r_parity;
`endif

  // Load data/source on enable, otherwise hold them; valid pulses for one cycle per load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_src_ram <= 1'b0;
`ifdef MUX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_valid <= i_enable;
      if (i_enable) begin
        r_data    <= i_data;
        r_src_ram <= i_src_ram;
`ifdef MUX_PARITY_EN
        // Parity of the incoming word equals parity of the value being stored
        r_parity  <= ^i_data;
`endif
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_src_ram = r_src_ram;
`ifdef MUX_PARITY_EN
  assign o_parity  = r_parity;
`endif

endmodule : mux_out_reg

// File: rtl/mux_4b.sv
// mux_4b: selects the program ROM or RAM nibble and presents it registered,
// with a one-cycle valid flag and the source that produced it.
// Optional feature: define MUX_PARITY_EN to add out_parity (XOR of outBits).
module mux_4b
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_4b_if.slave  bus
);

  logic [WIDTH-1:0] w_data;
  logic             w_src_ram;

  // Source select; anything other than a clean RAM select falls back to the ROM
  always_comb begin
    w_data    = bus.programROM;
    w_src_ram = SEL_ROM;
    if (bus.sel == SEL_RAM) begin
      w_data    = bus.Ram;
      w_src_ram = SEL_RAM;
    end
  end

  mux_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_enable  (bus.enable),
    .i_data    (w_data),
    .i_src_ram (w_src_ram),
    .o_data    (bus.outBits),
    .o_valid   (bus.out_valid),
`ifdef MUX_PARITY_EN
    .o_parity  (bus.out_parity),
`endif
    .o_src_ram (bus.src_ram)
  );

  // An unknown select while loading is a protocol violation by the driver
  a_sel_known : assert property (
    @(posedge clk) disable iff (!rst_n) bus.enable |-> !$isunknown(bus.sel)
  );

endmodule : mux_4b

// File: tb/tb_mux_4b.sv
// Scoreboard bench for mux_4b: directed cases then random traffic.
// Define MUX_PARITY_EN to also check out_parity.
module tb_mux_4b;
  import mux_pkg::*;

  logic clk;
  logic rst_n;

  mux_4b_if #(.WIDTH(MUX_WIDTH_DEF)) bus ();

  mux_4b #(.WIDTH(MUX_WIDTH_DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic    valid;
    nibble_t data;
    logic    src;
    logic    parity;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state: what the consumer should see after the next edge
  nibble_t model_data;
  logic    model_src;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the outputs must be after the edge
  task automatic drive(input logic en, input logic sel, input nibble_t rom, input nibble_t ram);
    exp_t e;
    @(negedge clk);
    bus.enable     = en;
    bus.sel        = sel;
    bus.programROM = rom;
    bus.Ram        = ram;
    if (en) begin
      model_data = sel ? ram : rom;
      model_src  = sel;
    end
    e.valid  = en;
    e.data   = model_data;
    e.src    = model_src;
    e.parity = ^model_data;
    exp_q.push_back(e);
    $display("drive en=%0d sel=%0d rom=%h ram=%h -> exp valid=%0d data=%h src=%0d",
             en, sel, rom, ram, e.valid, e.data, e.src);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: one entry per sampled edge, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_valid", int'(bus.out_valid), int'(e.valid));
        check("outBits", int'(bus.outBits), int'(e.data));
        check("src_ram", int'(bus.src_ram), int'(e.src));
`ifdef MUX_PARITY_EN
        check("out_parity", int'(bus.out_parity), int'(e.parity));
`endif
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_outBits"}, int'(bus.outBits), 0);
    check({tag, "_valid"}, int'(bus.out_valid), 0);
    check({tag, "_src"}, int'(bus.src_ram), 0);
`ifdef MUX_PARITY_EN
    check({tag, "_parity"}, int'(bus.out_parity), 0);
`endif
  endtask

  initial begin
    nibble_t rom, ram;
    logic en, sel;

    bus.enable = 1'b0; bus.sel = 1'b0; bus.programROM = '0; bus.Ram = '0;
    model_data = '0; model_src = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Equal sources, ROM selected
    drive(1'b1, SEL_ROM, 4'hF, 4'hF);
    // RAM selected
    drive(1'b1, SEL_RAM, 4'hF, 4'h7);
    // Hold with enable low for two edges
    drive(1'b0, SEL_ROM, 4'h3, 4'h5);
    drive(1'b0, SEL_ROM, 4'h3, 4'h5);
    // Equal sources, RAM selected: same data, source still recorded
    drive(1'b1, SEL_RAM, 4'hF, 4'hF);
    // Parity pair 7 then 6
    drive(1'b1, SEL_ROM, 4'h7, 4'h0);
    drive(1'b1, SEL_RAM, 4'h0, 4'h6);

    // Asynchronous reset between edges
    drive(1'b1, SEL_ROM, 4'hA, 4'h1);
    drain();
    check("pre_reset_outBits", int'(bus.outBits), 'hA);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    model_data = '0; model_src = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // sel toggling every edge
    for (int i = 0; i < 4; i++)
      drive(1'b1, logic'(i[0]), 4'h2, 4'hC);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      en  = logic'($urandom_range(0, 3) != 0);
      sel = logic'($urandom_range(0, 1));
      rom = nibble_t'($urandom);
      ram = nibble_t'($urandom);
      drive(en, sel, rom, ram);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_4b
